ps2_key_queue_ctrl: RTL and testbench

Sits between the PS2 keyboard interface and the processor, and decides when the processor sees each keyboard event. Each key_pressed pulse delivers one byte, which a small FSM parses as a prefix (E0 extended, F0 break) or a scan code. Completed key events are queued in a FIFO and handed to the processor through a valid/ack handshake plus a level interrupt. It also exports the most recent make code for the hex display and a sticky overflow flag.

---
 rtl/ps2_key_pkg.sv | 24 ++
 rtl/ps2_key_queue_ctrl_if.sv | 30 +++
 rtl/ps2_key_fifo.sv | 60 ++++++
 rtl/ps2_key_queue_ctrl.sv | 125 ++++++++++++
 tb/tb_ps2_key_queue_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/ps2_key_pkg.sv
// Shared definitions for the PS2 key queue: prefix bytes, parser states and queue entry layout.
package ps2_key_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } key_state_t;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } key_entry_t;

  function automatic logic is_prefix(input logic [7:0] b);
    return (b == SC_EXT) || (b == SC_BRK);
  endfunction

endpackage

// File: rtl/ps2_key_queue_ctrl_if.sv
// Keyboard-side byte strobe plus processor-side queue/handshake signals of the key queue controller.
interface ps2_key_queue_ctrl_if #(
  parameter int AW = 3
);
  logic [7:0]  key_data;
  logic        key_pressed;
  logic        irq_en;
  logic        rd_ack;
  logic        clr_overflow;
  logic        rd_valid;
  logic [7:0]  key_code;
  logic        key_ext;
  logic        key_brk;
  logic [AW:0] count;
  logic        irq;
  logic        overflow;
  logic [7:0]  last_make;

  // Controller side
  modport master (
    input  key_data, key_pressed, irq_en, rd_ack, clr_overflow,
    output rd_valid, key_code, key_ext, key_brk, count, irq, overflow, last_make
  );

  // Keyboard/processor side
  modport slave (
    output key_data, key_pressed, irq_en, rd_ack, clr_overflow,
    input  rd_valid, key_code, key_ext, key_brk, count, irq, overflow, last_make
  );
endinterface

// File: rtl/ps2_key_fifo.sv
// First-word fall-through queue of parsed key events; head reads zero while empty.
module ps2_key_fifo
  import ps2_key_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        i_push,
  input  key_entry_t  i_data,
  input  logic        i_pop,
  output key_entry_t  o_data,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count,
  output logic        o_drop
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  key_entry_t    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);

  // A pop frees a slot on the same edge, so a full queue still accepts a push alongside it
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_drop    = i_push & ~w_do_push;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ps2_key_queue_ctrl.sv
// Parses PS2 bytes into make/break events, queues them for the processor and raises a level interrupt.
module ps2_key_queue_ctrl
  import ps2_key_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int AW           = 3,
  parameter int FILTER_BREAK = 1
) (
  input  logic                 clock,
  input  logic                 resetn,
  ps2_key_queue_ctrl_if.master bus
);

  localparam bit KEEP_BRK = (FILTER_BREAK == 0);

  key_state_t  r_state;
  key_state_t  w_state_nxt;
  logic        r_kp_d;
  logic [7:0]  r_last_make;
  logic        r_overflow;

  logic        w_byte_stb;
  logic        w_make;
  logic        w_brk_evt;
  logic        w_ext;
  logic        w_push;
  key_entry_t  w_entry;
  key_entry_t  w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_drop;
  logic [AW:0] w_count;

  // A held strobe is consumed once: only the 0->1 transition counts
  assign w_byte_stb = bus.key_pressed & ~r_kp_d;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_kp_d      <= 1'b0;
      r_last_make <= 8'h00;
      r_overflow  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_kp_d  <= bus.key_pressed;
      if (w_make) r_last_make <= bus.key_data;
      if (w_drop)                r_overflow <= 1'b1;
      else if (bus.clr_overflow) r_overflow <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk_evt   = 1'b0;
    w_ext       = 1'b0;
    if (w_byte_stb) begin
      case (r_state)
        ST_IDLE: begin
          if (bus.key_data == SC_EXT)      w_state_nxt = ST_EXT;
          else if (bus.key_data == SC_BRK) w_state_nxt = ST_BRK;
          else                             w_make      = 1'b1;
        end
        ST_EXT: begin
          if (bus.key_data == SC_BRK) begin
            w_state_nxt = ST_EXT_BRK;
          end else if (bus.key_data != SC_EXT) begin
            w_make      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        // Repeated prefixes after F0 are malformed and simply absorbed
        ST_BRK: begin
          if (!is_prefix(bus.key_data)) begin
            w_brk_evt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_EXT_BRK: begin
          if (!is_prefix(bus.key_data)) begin
            w_brk_evt   = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_push       = w_make | (w_brk_evt & KEEP_BRK);
  assign w_entry.brk  = w_brk_evt;
  assign w_entry.ext  = w_ext;
  assign w_entry.code = bus.key_data;

  ps2_key_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clock   (clock),
    .resetn  (resetn),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (bus.rd_ack),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count),
    .o_drop  (w_drop)
  );

  assign bus.rd_valid  = ~w_empty;
  assign bus.key_code  = w_head.code;
  assign bus.key_ext   = w_head.ext;
  assign bus.key_brk   = w_head.brk;
  assign bus.count     = w_count;
  assign bus.irq       = ~w_empty & bus.irq_en;
  assign bus.overflow  = r_overflow;
  assign bus.last_make = r_last_make;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_ps2_key_queue_ctrl.sv
// Directed bench: two controllers (breaks kept / breaks filtered) driven by the same byte stream.
module tb_ps2_key_queue_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] kd = 8'h00;
  logic       kp = 1'b0;
  logic       ien = 1'b0;
  logic       ack = 1'b0;
  logic       clr = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ps2_key_queue_ctrl_if #(.AW(3)) if0 ();
  ps2_key_queue_ctrl_if #(.AW(3)) if1 ();

  assign if0.key_data = kd;  assign if1.key_data = kd;
  assign if0.key_pressed = kp;  assign if1.key_pressed = kp;
  assign if0.irq_en = ien;  assign if1.irq_en = ien;
  assign if0.rd_ack = ack;  assign if1.rd_ack = ack;
  assign if0.clr_overflow = clr;  assign if1.clr_overflow = clr;

  ps2_key_queue_ctrl #(.DEPTH(8), .AW(3), .FILTER_BREAK(0)) u_dut0 (
    .clock(clk), .resetn(rstn), .bus(if0.master));
  ps2_key_queue_ctrl #(.DEPTH(8), .AW(3), .FILTER_BREAK(1)) u_dut1 (
    .clock(clk), .resetn(rstn), .bus(if1.master));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    kd = b;
    kp = 1'b1;
    @(negedge clk);
    kp = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic head0(input string tag, input logic brk, input logic ext, input logic [7:0] code);
    chk({tag, "_code"}, 32'(if0.key_code), 32'(code));
    chk({tag, "_ext"},  32'(if0.key_ext),  32'(ext));
    chk({tag, "_brk"},  32'(if0.key_brk),  32'(brk));
  endtask

  initial begin
    // Reset state
    ien = 1'b1;
    #12;
    chk("rst_valid", 32'(if0.rd_valid), 32'd0);
    chk("rst_count", 32'(if0.count), 32'd0);
    chk("rst_irq", 32'(if0.irq), 32'd0);
    chk("rst_ovf", 32'(if0.overflow), 32'd0);
    chk("rst_last", 32'(if0.last_make), 32'h00);
    chk("rst_code", 32'(if0.key_code), 32'h00);
    @(negedge clk);
    rstn = 1'b1;
    ien = 1'b0;

    // 1: held strobe gives exactly one entry
    @(negedge clk);
    kd = 8'h1C;
    kp = 1'b1;
    repeat (3) @(negedge clk);
    kp = 1'b0;
    chk("t1_count", 32'(if0.count), 32'd1);
    chk("t1_valid", 32'(if0.rd_valid), 32'd1);
    head0("t1", 1'b0, 1'b0, 8'h1C);
    chk("t1_last", 32'(if0.last_make), 32'h1C);
    chk("t1_irq_off", 32'(if0.irq), 32'd0);
    ien = 1'b1;
    #1;
    chk("t1_irq_on", 32'(if0.irq), 32'd1);
    pop();
    chk("t1_pop_count", 32'(if0.count), 32'd0);
    chk("t1_pop_irq", 32'(if0.irq), 32'd0);
    chk("t1_f_count", 32'(if1.count), 32'd0);

    // 2: extended make then extended break
    send(8'hE0); send(8'h75);
    chk("t2_first_lat", 32'(if0.count), 32'd1);
    send(8'hE0); send(8'hF0); send(8'h75);
    chk("t2_count", 32'(if0.count), 32'd2);
    head0("t2_h0", 1'b0, 1'b1, 8'h75);
    chk("t2_f_count", 32'(if1.count), 32'd1);
    pop();
    chk("t2_count1", 32'(if0.count), 32'd1);
    head0("t2_h1", 1'b1, 1'b1, 8'h75);
    pop();
    chk("t2_count0", 32'(if0.count), 32'd0);
    chk("t2_valid", 32'(if0.rd_valid), 32'd0);
    chk("t2_f_count0", 32'(if1.count), 32'd0);
    chk("t2_last", 32'(if0.last_make), 32'h75);

    // 3: plain break; filtered on dut1, kept on dut0
    send(8'hF0); send(8'h1C);
    chk("t3_f_count", 32'(if1.count), 32'd0);
    chk("t3_f_last", 32'(if1.last_make), 32'h75);
    chk("t3_count", 32'(if0.count), 32'd1);
    head0("t3_h", 1'b1, 1'b0, 8'h1C);
    chk("t3_last", 32'(if0.last_make), 32'h75);
    pop();

    // 4: overflow with nine makes
    for (int i = 1; i <= 9; i++) send(8'(i));
    chk("t4_count", 32'(if0.count), 32'd8);
    chk("t4_ovf", 32'(if0.overflow), 32'd1);
    chk("t4_f_ovf", 32'(if1.overflow), 32'd1);
    chk("t4_head", 32'(if0.key_code), 32'h01);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("t4_pop%0d", i), 32'(if0.key_code), 32'(i));
      pop();
    end
    chk("t4_empty", 32'(if0.rd_valid), 32'd0);
    chk("t4_ovf_hold", 32'(if0.overflow), 32'd1);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("t4_clr", 32'(if0.overflow), 32'd0);

    // 5: push and pop together while full
    for (int i = 1; i <= 8; i++) send(8'(i));
    chk("t5_full", 32'(if0.count), 32'd8);
    @(negedge clk);
    kd = 8'h33;
    kp = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    kp = 1'b0;
    ack = 1'b0;
    chk("t5_count", 32'(if0.count), 32'd8);
    chk("t5_ovf", 32'(if0.overflow), 32'd0);
    chk("t5_head", 32'(if0.key_code), 32'h02);
    for (int i = 2; i <= 9; i++) begin
      chk($sformatf("t5_pop%0d", i), 32'(if0.key_code), (i == 9) ? 32'h33 : 32'(i));
      pop();
    end
    chk("t5_empty", 32'(if0.count), 32'd0);
    pop();
    chk("t5_ack_empty", 32'(if0.count), 32'd0);
    chk("t5_ack_valid", 32'(if0.rd_valid), 32'd0);

    // 6: asynchronous reset mid-event
    send(8'h11); send(8'h22); send(8'h33); send(8'hE0);
    chk("t6_pre", 32'(if0.count), 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_count", 32'(if0.count), 32'd0);
    chk("t6_valid", 32'(if0.rd_valid), 32'd0);
    chk("t6_irq", 32'(if0.irq), 32'd0);
    chk("t6_last", 32'(if0.last_make), 32'h00);
    chk("t6_code", 32'(if0.key_code), 32'h00);
    @(negedge clk);
    rstn = 1'b1;
    send(8'h75);
    chk("t6_after_count", 32'(if0.count), 32'd1);
    head0("t6_after", 1'b0, 1'b0, 8'h75);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
